alu_share_arbiter: RTL and testbench

//  Shares one combinational 8-bit flag-producing ALU (ops ADD,SUB,AND,OR,XOR,NOT,SHL,SHR; flags Z,C,N)

---
 rtl/alu_share_arbiter_if.sv | 27 ++
 rtl/alu_share_arbiter.sv | 132 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_share_arbiter_if.sv
// Request/response bus between two issue units and the shared-ALU arbiter.
// The arbiter sits on the slave modport; issuers and the response consumer use the master modport.
interface alu_share_arbiter_if #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3
);
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [2*WIDTH-1:0] req_a;
    logic [2*WIDTH-1:0] req_b;
    logic [2*OPW-1:0]   req_op;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_id;
    logic [WIDTH-1:0]   rsp_result;
    logic [2:0]         rsp_flags;

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Shares one combinational flag-producing ALU between two requesters: grant, issue registered
// operands, capture result and flags, and return them on a tagged valid/ready response channel.
module alu_share_arbiter #(
    parameter int WIDTH = 8,
    parameter int OPW   = 3,
    parameter int FAIR  = 1,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    output logic [OPW-1:0]     alu_op,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_zero,
    input  logic               alu_carry,
    input  logic               alu_negative,
    output logic               busy,
    output logic [CNTW-1:0]    op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [1:0]       gnt;
    logic             gnt_id;
    logic [1:0]       ready_c;
    logic             last_grant;
    logic             accept;
    logic             rsp_fire;

    logic [WIDTH-1:0] a_p0;
    logic [WIDTH-1:0] b_p0;
    logic [OPW-1:0]   op_p0;
    logic             id_p0;

    logic [WIDTH-1:0] result_p1;
    logic [2:0]       flags_p1;
    logic             id_p1;

    logic [CNTW-1:0]  cnt_q;

    // Contention goes to the requester not served last time unless fixed priority is selected.
    always_comb begin
        gnt = 2'b00;
        case (bus.req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = ((FAIR != 0) && !last_grant) ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
        endcase
    end

    assign gnt_id = gnt[1];

    always_comb begin
        state_d = state_q;
        ready_c = 2'b00;
        case (state_q)
            IDLE: begin
                if (gnt != 2'b00) begin
                    ready_c = gnt;
                    state_d = EXEC;
                end
            end
            EXEC:    state_d = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept   = (state_q == IDLE) && (gnt != 2'b00);
    assign rsp_fire = (state_q == RESP) && bus.rsp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            a_p0       <= '0;
            b_p0       <= '0;
            op_p0      <= '0;
            id_p0      <= 1'b0;
            result_p1  <= '0;
            flags_p1   <= 3'b000;
            id_p1      <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            // Stage p0: winning operands latched into the ALU issue registers.
            if (accept) begin
                a_p0       <= gnt_id ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                b_p0       <= gnt_id ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                op_p0      <= gnt_id ? bus.req_op[2*OPW-1:OPW]    : bus.req_op[OPW-1:0];
                id_p0      <= gnt_id;
                last_grant <= gnt_id;
            end
            // Stage p1: ALU output captured into the response registers.
            if (state_q == EXEC) begin
                result_p1 <= alu_result;
                flags_p1  <= {alu_zero, alu_carry, alu_negative};
                id_p1     <= id_p0;
            end
            if (rsp_fire) begin
                cnt_q <= cnt_q + CNTW'(1);
            end
        end
    end

    // Gated by reset so the request side reads idle while the block is held in reset.
    assign bus.req_ready  = rst_n ? ready_c : 2'b00;
    assign bus.rsp_valid  = (state_q == RESP);
    assign bus.rsp_id     = id_p1;
    assign bus.rsp_result = result_p1;
    assign bus.rsp_flags  = flags_p1;

    assign alu_a    = a_p0;
    assign alu_b    = b_p0;
    assign alu_op   = op_p0;
    assign busy     = (state_q != IDLE);
    assign op_count = cnt_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: bench-side ALU, transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, random traffic and a fixed-priority instance.
module tb_alu_share_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    // Reference ALU: returns {zero, carry, negative, result}; carry on SUB is the borrow.
    function automatic logic [10:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        logic [8:0] w;
        case (op)
            3'd0:    w = {1'b0, a} + {1'b0, b};
            3'd1:    w = {1'b0, a} - {1'b0, b};
            3'd2:    w = {1'b0, a & b};
            3'd3:    w = {1'b0, a | b};
            3'd4:    w = {1'b0, a ^ b};
            3'd5:    w = {1'b0, ~a};
            3'd6:    w = {1'b0, a[6:0], 1'b0};
            default: w = {1'b0, 1'b0, a[7:1]};
        endcase
        return {(w[7:0] == 8'h00), w[8], w[7], w[7:0]};
    endfunction

    // Round-robin instance under full checking
    alu_share_arbiter_if bus1 ();
    logic [7:0]  a1, b1;
    logic [2:0]  op1;
    logic [10:0] f1;
    logic        busy1;
    logic [15:0] cnt1;

    always_comb f1 = alu_f(a1, b1, op1);

    alu_share_arbiter #(.WIDTH(8), .OPW(3), .FAIR(1), .CNTW(16)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus1),
        .alu_a(a1), .alu_b(b1), .alu_op(op1),
        .alu_result(f1[7:0]), .alu_zero(f1[10]), .alu_carry(f1[9]), .alu_negative(f1[8]),
        .busy(busy1), .op_count(cnt1)
    );

    // Fixed-priority instance with a narrow counter so the wrap is reachable
    alu_share_arbiter_if bus2 ();
    logic [7:0]  a2, b2;
    logic [2:0]  op2;
    logic [10:0] f2;
    logic        busy2;
    logic [3:0]  cnt2;

    always_comb f2 = alu_f(a2, b2, op2);

    alu_share_arbiter #(.WIDTH(8), .OPW(3), .FAIR(0), .CNTW(4)) dut_fix (
        .clk(clk), .rst_n(rst_n), .bus(bus2),
        .alu_a(a2), .alu_b(b2), .alu_op(op2),
        .alu_result(f2[7:0]), .alu_zero(f2[10]), .alu_carry(f2[9]), .alu_negative(f2[8]),
        .busy(busy2), .op_count(cnt2)
    );

    // Transaction-level model of the round-robin instance
    bit          m_has = 1'b0;
    int          m_age = 0;
    logic        m_last = 1'b1;
    logic [7:0]  m_a = '0, m_b = '0, m_res = '0;
    logic [2:0]  m_op = '0, m_fl = '0;
    logic        m_id = 1'b0, m_rid = 1'b0;
    logic [15:0] m_cnt = '0;
    logic [1:0]  m_g;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_has = 1'b0; m_age = 0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_op = '0; m_id = 1'b0;
            m_res = '0; m_fl = '0; m_rid = 1'b0; m_cnt = '0;
        end
        m_g = 2'b00;
        if (rst_n && !m_has) begin
            if (bus1.req_valid == 2'b11) m_g = m_last ? 2'b01 : 2'b10;
            else m_g = bus1.req_valid;
        end
        chk("req_ready",  32'(bus1.req_ready),  32'(m_g));
        chk("busy",       32'(busy1),           32'(m_has));
        chk("rsp_valid",  32'(bus1.rsp_valid),  32'(m_has && m_age >= 2));
        chk("alu_a",      32'(a1),              32'(m_a));
        chk("alu_b",      32'(b1),              32'(m_b));
        chk("alu_op",     32'(op1),             32'(m_op));
        chk("rsp_id",     32'(bus1.rsp_id),     32'(m_rid));
        chk("rsp_result", 32'(bus1.rsp_result), 32'(m_res));
        chk("rsp_flags",  32'(bus1.rsp_flags),  32'(m_fl));
        chk("op_count",   32'(cnt1),            32'(m_cnt));
        if (rst_n) begin
            if (m_has) begin
                if (m_age >= 2) begin
                    if (bus1.rsp_ready) begin
                        m_has = 1'b0;
                        m_cnt = m_cnt + 16'd1;
                    end
                end else begin
                    m_age++;
                    if (m_age == 2) begin
                        {m_fl, m_res} = alu_f(m_a, m_b, m_op);
                        m_rid = m_id;
                    end
                end
            end else if (m_g != 2'b00) begin
                m_id   = m_g[1];
                m_last = m_g[1];
                m_a    = m_g[1] ? bus1.req_a[15:8] : bus1.req_a[7:0];
                m_b    = m_g[1] ? bus1.req_b[15:8] : bus1.req_b[7:0];
                m_op   = m_g[1] ? bus1.req_op[5:3] : bus1.req_op[2:0];
                m_has  = 1'b1;
                m_age  = 1;
            end
        end
    end

    // Fixed-priority checks: requester 1 never granted, all responses tagged 0, counter wraps mod 16
    bit         fix_en = 1'b0;
    logic [3:0] f_cnt = '0;
    int         f_done = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            f_cnt = '0;
        end else if (fix_en) begin
            chk("fix_req_ready1", 32'(bus2.req_ready[1]), 32'(0));
            if (bus2.rsp_valid) chk("fix_rsp_id", 32'(bus2.rsp_id), 32'(0));
            chk("fix_op_count", 32'(cnt2), 32'(f_cnt));
            if (bus2.rsp_valid && bus2.rsp_ready) begin
                f_cnt = f_cnt + 4'd1;
                f_done++;
            end
        end
    end

    // Issue one op from one requester; returns at the negedge of the first response cycle.
    task automatic do_op(input bit who, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                         input bit rdy, output logic [7:0] res, output logic [2:0] fl,
                         output logic id, output int lat);
        int w;
        bus1.req_valid = 2'b00;
        bus1.req_valid[who] = 1'b1;
        if (who) begin
            bus1.req_a[15:8] = a; bus1.req_b[15:8] = b; bus1.req_op[5:3] = op;
        end else begin
            bus1.req_a[7:0] = a; bus1.req_b[7:0] = b; bus1.req_op[2:0] = op;
        end
        bus1.rsp_ready = rdy;
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!bus1.req_ready[who] && w < 20);
        chk("accepted", 32'(bus1.req_ready[who]), 32'(1));
        @(posedge clk);
        #1 bus1.req_valid = 2'b00;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!bus1.rsp_valid && lat < 20);
        chk("rsp_seen", 32'(bus1.rsp_valid), 32'(1));
        res = bus1.rsp_result;
        fl  = bus1.rsp_flags;
        id  = bus1.rsp_id;
    endtask

    logic [7:0]  r;
    logic [2:0]  fl;
    logic        id;
    int          lat;
    int          seen;
    logic [15:0] cnt_before;
    logic [7:0]  t3_res [4];
    logic [2:0]  t3_fl  [4];
    logic        t3_id  [4];
    int          t3_n;

    initial begin
        bus1.req_valid = 2'b00; bus1.req_a = '0; bus1.req_b = '0; bus1.req_op = '0; bus1.rsp_ready = 1'b0;
        bus2.req_valid = 2'b00; bus2.req_a = '0; bus2.req_b = '0; bus2.req_op = '0; bus2.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",      32'(busy1),          32'(0));
        chk("rst_req_ready", 32'(bus1.req_ready), 32'(0));
        chk("rst_rsp_valid", 32'(bus1.rsp_valid), 32'(0));
        chk("rst_op_count",  32'(cnt1),           32'(0));
        rst_n = 1'b1;

        // ADD 0F+01 from requester 0
        @(posedge clk); #1;
        do_op(1'b0, 8'h0F, 8'h01, 3'd0, 1'b1, r, fl, id, lat);
        chk("t2_result",  32'(r),   32'h10);
        chk("t2_flags",   32'(fl),  32'b000);
        chk("t2_id",      32'(id),  32'(0));
        chk("t2_latency", 32'(lat), 32'(2));
        @(posedge clk); #1;
        chk("t2_count", 32'(cnt1), 32'(1));

        // Reset while the op sits in EXEC
        bus1.req_valid = 2'b01; bus1.req_a[7:0] = 8'h33; bus1.req_b[7:0] = 8'h11; bus1.req_op[2:0] = 3'd1;
        seen = 0;
        do begin @(negedge clk); seen++; end while (!bus1.req_ready[0] && seen < 20);
        chk("t1_accepted", 32'(bus1.req_ready[0]), 32'(1));
        @(posedge clk); #1;
        chk("t1_busy_before", 32'(busy1), 32'(1));
        rst_n = 1'b0; bus1.req_valid = 2'b00;
        #1;
        chk("t1_busy",     32'(busy1),           32'(0));
        chk("t1_alu_a",    32'(a1),              32'(0));
        chk("t1_rsp",      32'(bus1.rsp_result), 32'(0));
        chk("t1_op_count", 32'(cnt1),            32'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus1.rsp_valid) seen++;
        end
        chk("t1_no_rsp",    32'(seen), 32'(0));
        chk("t1_count_end", 32'(cnt1), 32'(0));

        // Contention after reset: requester 0 first, then strict alternation
        @(posedge clk); #1;
        bus1.req_a = {8'hFF, 8'h10}; bus1.req_b = {8'h01, 8'h10}; bus1.req_op = {3'd0, 3'd1};
        bus1.rsp_ready = 1'b1; bus1.req_valid = 2'b11;
        t3_n = 0;
        repeat (14) begin
            @(negedge clk);
            if (bus1.rsp_valid && t3_n < 4) begin
                t3_res[t3_n] = bus1.rsp_result; t3_fl[t3_n] = bus1.rsp_flags; t3_id[t3_n] = bus1.rsp_id;
                t3_n++;
            end
        end
        chk("t3_count",   32'(t3_n),      32'(4));
        chk("t3_res0",    32'(t3_res[0]), 32'h00);
        chk("t3_fl0",     32'(t3_fl[0]),  32'b100);
        chk("t3_id0",     32'(t3_id[0]),  32'(0));
        chk("t3_res1",    32'(t3_res[1]), 32'h00);
        chk("t3_fl1",     32'(t3_fl[1]),  32'b110);
        chk("t3_id1",     32'(t3_id[1]),  32'(1));
        chk("t3_id2",     32'(t3_id[2]),  32'(0));
        chk("t3_id3",     32'(t3_id[3]),  32'(1));
        @(posedge clk); #1 bus1.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // Back-pressure: XOR F0^0F from requester 1 held in RESP while requester 0 waits
        do_op(1'b1, 8'hF0, 8'h0F, 3'd4, 1'b0, r, fl, id, lat);
        chk("t4_result", 32'(r),  32'hFF);
        chk("t4_flags",  32'(fl), 32'b001);
        chk("t4_id",     32'(id), 32'(1));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            bus1.req_valid = 2'b01; bus1.req_a[7:0] = 8'h05; bus1.req_b[7:0] = 8'h03; bus1.req_op[2:0] = 3'd2;
            @(negedge clk);
            chk("t4_hold_result", 32'(bus1.rsp_result), 32'hFF);
            chk("t4_hold_flags",  32'(bus1.rsp_flags),  32'b001);
            chk("t4_hold_busy",   32'(busy1),           32'(1));
            chk("t4_hold_ready",  32'(bus1.req_ready),  32'(0));
        end
        cnt_before = cnt1;
        @(posedge clk); #1 bus1.rsp_ready = 1'b1;
        @(posedge clk); #1;
        chk("t4_idle_busy",  32'(busy1),          32'(0));
        chk("t4_count_inc",  32'(cnt1),           32'(cnt_before + 16'd1));
        chk("t4_next_grant", 32'(bus1.req_ready), 32'(2'b01));
        @(posedge clk); #1 bus1.req_valid = 2'b00;
        repeat (4) @(posedge clk);
        #1;

        // SHR 80 from requester 1
        do_op(1'b1, 8'h80, 8'h00, 3'd7, 1'b1, r, fl, id, lat);
        chk("t6_result", 32'(r),  32'h40);
        chk("t6_flags",  32'(fl), 32'b000);
        chk("t6_id",     32'(id), 32'(1));
        @(posedge clk); #1;

        // Random traffic including withdrawn requests and stalled responses
        for (int i = 0; i < 400; i++) begin
            bus1.req_valid = 2'($urandom);
            bus1.req_a     = 16'($urandom);
            bus1.req_b     = 16'($urandom);
            bus1.req_op    = 6'($urandom);
            bus1.rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        bus1.req_valid = 2'b00; bus1.rsp_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Fixed priority with both requesters always pending
        fix_en = 1'b1;
        bus2.req_valid = 2'b11; bus2.rsp_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            bus2.req_a  = 16'($urandom);
            bus2.req_b  = 16'($urandom);
            bus2.req_op = 6'($urandom);
            @(posedge clk); #1;
        end
        chk("fix_ops_done", 32'(f_done > 16), 32'(1));
        fix_en = 1'b0;
        bus2.req_valid = 2'b00;
        repeat (3) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d/%0d", n_pass, n_chk);
        $fatal(1, "watchdog");
    end

endmodule
